// File: rtl/dip_code_decoder.sv
// Receive-side decoder for the 7-position DIP-switch code: synchronises and debounces
// the 3-bit header code, then drives a one-hot LED select, a change pulse and an idle blink.
module dip_code_decoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code_in,
  output logic [6:0] led,
  output logic       code_valid,
  output logic       code_change,
  output logic       idle_blink
);

  localparam int         CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int         BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [2:0] NONE    = 3'b111;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic {STABLE, SETTLE} state_t;

  state_t             state;
  logic [2:0]         sync1, sync2;
  logic [2:0]         stable, candidate;
  logic [CNT_W-1:0]   cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               commit;
  logic [2:0]         stable_next;

  // Encoder map: channel index = 6 - code, code 111 selects nothing.
  function automatic logic [6:0] decode(input logic [2:0] code);
    case (code)
      3'b110:  decode = 7'b0000001;
      3'b101:  decode = 7'b0000010;
      3'b100:  decode = 7'b0000100;
      3'b011:  decode = 7'b0001000;
      3'b010:  decode = 7'b0010000;
      3'b001:  decode = 7'b0100000;
      3'b000:  decode = 7'b1000000;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // The blink logic must see the code that will be accepted on this edge, so a commit
  // into a channel silences the indicator on the same edge the LED lights.
  assign commit      = (state == SETTLE) && (sync2 == candidate) && (cnt == CNT_LAST);
  assign stable_next = commit ? candidate : stable;

  // NOTE: every register here uses non-blocking assignment so all flops sample the
  // pre-edge values; blocking assignment would collapse the two-flop synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= STABLE;
      sync1       <= NONE;
      sync2       <= NONE;
      stable      <= NONE;
      candidate   <= NONE;
      cnt         <= '0;
      blink_cnt   <= '0;
      led         <= '0;
      code_valid  <= 1'b0;
      code_change <= 1'b0;
      idle_blink  <= 1'b0;
    end else begin
      sync1       <= code_in;
      sync2       <= sync1;
      code_change <= 1'b0;

      case (state)
        STABLE: begin
          if (sync2 != stable) begin
            candidate <= sync2;
            cnt       <= '0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 != candidate) begin
            candidate <= sync2;
            cnt       <= '0;
          end else if (commit) begin
            stable      <= candidate;
            led         <= decode(candidate);
            code_valid  <= (candidate != NONE);
            code_change <= (candidate != stable);
            state       <= STABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      // Counting only runs while idle both before and after this edge, so entering
      // the idle code restarts the square wave from zero.
      if (stable_next != NONE || stable != NONE) begin
        blink_cnt  <= '0;
        idle_blink <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt  <= '0;
        idle_blink <= ~idle_blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/dip_code_decoder.md
# dip_code_decoder

Receive-side counterpart to the board's 7-position DIP-switch encoder. Accepts the 3-bit encoded switch code arriving from an external pin header, synchronises and debounces it, and decodes it back into a one-hot 7-channel LED select. Also flags changes and blinks an idle indicator when no switch is selected. Sits between the header pins and the LED bank on the Cyclone II board.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: number of consecutive stable cycles required to accept a new code; 1 ms at 50 MHz; minimum 1.
- BLINK_CYCLES, default 25000000: idle indicator half-period in clock cycles; minimum 1.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- code_in, input, 3: raw asynchronous encoded code from the header.
- led, output, 7: one-hot channel select; bit k = channel k; active-high.
- code_valid, output, 1: high while the accepted code selects a channel.
- code_change, output, 1: one-cycle pulse when the accepted code changes value.
- idle_blink, output, 1: square wave while no channel is selected; 0 otherwise.

## Operation
- Code map, fixed by the encoder: 3'b110→ch0, 101→ch1, 100→ch2, 011→ch3, 010→ch4, 001→ch5, 000→ch6, 111→none. Channel index = 6 − code for code ≠ 111.
- Synchroniser: two flops, sync1 then sync2; both reset to 3'b111.
- Registers: stable (accepted code, reset 111), candidate (reset 111), cnt (width $clog2(DEBOUNCE_CYCLES+1), reset 0).
- FSM states, reset to STABLE:
  - STABLE: if sync2 ≠ stable, load candidate ← sync2, cnt ← 0, go to SETTLE. Otherwise hold.
  - SETTLE: if sync2 ≠ candidate (bounce), reload candidate ← sync2 and cnt ← 0; stay in SETTLE.
  - SETTLE, else if cnt == DEBOUNCE_CYCLES−1: commit stable ← candidate and go to STABLE. Otherwise cnt ← cnt+1.
- Commit:
  - Update led and code_valid on the same edge.
  - Pulse code_change for exactly one cycle only if candidate ≠ old stable.
  - A glitch that returns to the old value commits silently.
- led: all zeros when stable == 111; else only bit (6 − stable) set.
- code_valid = (stable ≠ 111).
- All outputs are registered; no combinational path from code_in.
- Idle blink:
  - While stable == 111, blink counter increments. At BLINK_CYCLES−1, idle_blink toggles and the counter clears.
  - While stable ≠ 111, counter and idle_blink are held at 0.
  - On commit into 111, both start from 0.
- rst has priority over all other logic.
  - Reset values: led = 0, code_valid = 0, code_change = 0, idle_blink = 0, stable = candidate = 111, cnt = 0, blink counter = 0, state STABLE.
  - Reset during SETTLE discards the candidate and produces no pulse.

## Timing
- Input change sampled at edge E1 reaches sync2 at E2 and loads candidate at E3.
- Commit occurs at edge E(DEBOUNCE_CYCLES+3), provided code_in stays constant.
  - Total latency is DEBOUNCE_CYCLES+3 cycles (7 cycles when DEBOUNCE_CYCLES = 4).
- Any bounce restarts the full DEBOUNCE_CYCLES window from the edge the new value appears in sync2.
- code_change is high exactly one cycle, coincident with the first cycle of the new led value.
- Direct code-to-code transitions (e.g. 110→101) change led in a single edge, with no all-zero cycle in between.
- With code constant at 111 after reset, idle_blink first rises at edge BLINK_CYCLES and toggles every BLINK_CYCLES thereafter.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and BLINK_CYCLES = 8.
- Reset with code_in = 111, held for 40 cycles → led = 0, code_valid = 0, code_change never high; idle_blink toggles at cycles 8, 16, 24, 32.
- code_in 111→110 held → exactly 7 cycles later led = 7'b0000001, code_valid = 1, code_change high for 1 cycle; idle_blink = 0 from that edge.
- From stable 110, drive 101 for 2 cycles then back to 110 → led stays 0000001; code_change stays 0 throughout.
- Sweep code_in 000, 001, … 110, each held 12 cycles → led = one-hot bit (6 − code) each time; exactly one code_change pulse per step.
- From stable 011, set 111 → after 7 cycles led = 0, code_valid = 0, one code_change pulse; idle_blink first rises 8 cycles later.
- Assert rst for 1 cycle in the middle of SETTLE (cnt = 2) → next cycle all outputs at reset values, no code_change; same code then takes a full 7 cycles to commit.
